// File: rtl/vbs_timing_gen_if.sv
// ---------------------------------------------------------------------------------------------
// vbs_timing_gen_if
//   Bundles the video-side signals of vbs_timing_gen.
//   master : the timing generator (drives sync/pixel/strobes/fetch address, receives data).
//   slave  : the fetch logic and output pins (the opposite side).
// Signals
//   sync        0 = sync tip, 1 = not sync
//   pixel       luma bit, 0 outside the visible window
//   visible     active-window flag aligned with pixel/data
//   x, y        fetch column/row
//   req         1-clk strobe: x/y carry a new fetch address
//   data        fetched pixel bit, returned FETCH_LAT clocks after req
//   valid       qualifier for data
//   line_start  1-clk strobe at hc==0
//   frame_start 1-clk strobe at hc==0, vc==0
//   field       field parity
// ---------------------------------------------------------------------------------------------
interface vbs_timing_gen_if #(
   parameter int unsigned XW = 9,
   parameter int unsigned YW = 8
) ();
   logic          sync;
   logic          pixel;
   logic          visible;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          req;
   logic          data;
   logic          valid;
   logic          line_start;
   logic          frame_start;
   logic          field;

   modport master (
      output sync, pixel, visible, x, y, req, line_start, frame_start, field,
      input  data, valid
   );

   modport slave (
      input  sync, pixel, visible, x, y, req, line_start, frame_start, field,
      output data, valid
   );
endinterface

// File: rtl/vbs_timing_gen.sv
// ---------------------------------------------------------------------------------------------
// vbs_timing_gen
//   Parametrised composite-video (VBS) timing generator. Produces line/field timing, sync tips,
//   broad vsync pulses, fetch coordinates leading the visible window by FETCH_LAT clocks,
//   horizontal pixel stretching (PIX_DIV) and line/frame strobes.
// Ports
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   vid      vbs_timing_gen_if.master (sync, pixel, visible, x, y, req, line_start,
//            frame_start, field out; data, valid in)
// Configuration
//   VBS_INTERLACE_EN : when defined, field toggles on every vc wrap, field=1 runs
//                      LINE_COUNT-1 lines and its line-0 broad pulse starts at H_TOTAL/2.
//                      When undefined, field is 0 and every field runs LINE_COUNT lines.
// ---------------------------------------------------------------------------------------------
module vbs_timing_gen #(
   parameter int unsigned H_TOTAL     = 512,
   parameter int unsigned LINE_COUNT  = 313,
   parameter int unsigned H_PIXELS    = 320,
   parameter int unsigned V_PIXELS    = 192,
   parameter int unsigned H_START     = 93,
   parameter int unsigned V_START     = 35,
   parameter int unsigned HSYNC_START = 2,
   parameter int unsigned HSYNC_LEN   = 28,
   parameter int unsigned VSYNC_LINES = 3,
   parameter int unsigned PIX_DIV     = 1,
   parameter int unsigned FETCH_LAT   = 1
) (
   input logic              clk,
   input logic              reset_n,
   vbs_timing_gen_if.master vid
);

   // Widths leave room for the exclusive end of every window (may equal H_TOTAL/LINE_COUNT).
   localparam int unsigned HW = $clog2(H_TOTAL + 1);
   localparam int unsigned VW = $clog2(LINE_COUNT + 1);
   localparam int unsigned XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
   localparam int unsigned YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

   localparam logic [HW-1:0] HLast    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] HsBeg    = HW'(HSYNC_START);
   localparam logic [HW-1:0] HsEnd    = HW'(HSYNC_START + HSYNC_LEN);
   localparam logic [HW-1:0] BroadEnd = HW'(H_TOTAL - HSYNC_LEN);
   localparam logic [HW-1:0] WinBeg   = HW'(H_START);
   localparam logic [HW-1:0] WinEnd   = HW'(H_START + H_PIXELS * PIX_DIV);
   localparam logic [HW-1:0] FetBeg   = HW'(H_START - FETCH_LAT);
   localparam logic [HW-1:0] FetEnd   = HW'(H_START - FETCH_LAT + H_PIXELS * PIX_DIV);
   localparam logic [VW-1:0] VLast    = VW'(LINE_COUNT - 1);
   localparam logic [VW-1:0] VsEnd    = VW'(VSYNC_LINES);
   localparam logic [VW-1:0] VaBeg    = VW'(V_START);
   localparam logic [VW-1:0] VaEnd    = VW'(V_START + V_PIXELS);
   localparam logic [XW-1:0] XLast    = XW'(H_PIXELS - 1);
   localparam logic [1:0]    DivLast  = 2'(PIX_DIV - 1);

   // Elaboration-time parameter checks
   if (PIX_DIV < 1 || PIX_DIV > 4) begin : g_chk_div
      $error("vbs_timing_gen: PIX_DIV must be 1..4");
   end
   if (FETCH_LAT > 3) begin : g_chk_lat
      $error("vbs_timing_gen: FETCH_LAT must be 0..3");
   end
   if (H_START < FETCH_LAT) begin : g_chk_lead
      $error("vbs_timing_gen: H_START must be >= FETCH_LAT");
   end
   if (H_START + H_PIXELS * PIX_DIV > H_TOTAL) begin : g_chk_hwin
      $error("vbs_timing_gen: horizontal window exceeds H_TOTAL");
   end
   if (V_START + V_PIXELS > LINE_COUNT) begin : g_chk_vwin
      $error("vbs_timing_gen: vertical window exceeds LINE_COUNT");
   end
   if (HSYNC_START + HSYNC_LEN >= H_START) begin : g_chk_sync
      $error("vbs_timing_gen: sync tip must end before H_START");
   end

   logic [HW-1:0] hc_q, hc_d;
   logic [VW-1:0] vc_q, vc_d;
   logic [1:0]    div_q, div_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          sync_q, sync_d;
   logic          visible_q, visible_d;
   logic          req_q, req_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic          field_out_q;

   logic          hc_wrap, vc_wrap;
   logic [VW-1:0] vc_last;
   logic          act_line, in_win, in_fetch;
   logic          in_tip, in_broad, sync_low;

`ifdef VBS_INTERLACE_EN
   localparam logic [VW-1:0] VLastShort = VW'(LINE_COUNT - 2);
   localparam logic [HW-1:0] HalfLine   = HW'(H_TOTAL / 2);

   logic field_q, field_d;

   assign vc_last = field_q ? VLastShort : VLast;
   assign field_d = (hc_wrap && vc_wrap) ? ~field_q : field_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         field_q <= 1'b0;
      end else begin
         field_q <= field_d;
      end
   end
`else
   logic field_q;

   assign vc_last = VLast;
   assign field_q = 1'b0;
`endif

   assign hc_wrap = (hc_q == HLast);
   assign vc_wrap = (vc_q == vc_last);

   always_comb begin
      hc_d = hc_wrap ? '0 : hc_q + 1'b1;
      vc_d = vc_q;
      if (hc_wrap) begin
         vc_d = vc_wrap ? '0 : vc_q + 1'b1;
      end

      in_tip   = (hc_q >= HsBeg) && (hc_q < HsEnd);
      in_broad = (hc_q >= HsBeg) && (hc_q < BroadEnd);
      sync_low = (vc_q < VsEnd) ? in_broad : in_tip;
`ifdef VBS_INTERLACE_EN
      // Odd field: line 0 keeps its tip and the broad pulse moves to the half line.
      if (field_q && (vc_q == '0)) begin
         sync_low = in_tip || ((hc_q >= HalfLine) && (hc_q < BroadEnd));
      end
`endif
      sync_d = ~sync_low;

      act_line = (vc_q >= VaBeg) && (vc_q < VaEnd);
      in_win   = act_line && (hc_q >= WinBeg) && (hc_q < WinEnd);
      in_fetch = act_line && (hc_q >= FetBeg) && (hc_q < FetEnd);

      // div_q is 0 on the first clock of each stretched pixel inside the fetch window.
      div_d = (in_fetch && (div_q != DivLast)) ? div_q + 2'd1 : 2'd0;
      req_d = in_fetch && (div_q == 2'd0);

      // x advances on the clock after each req so it already holds the next address.
      x_d = x_q;
      if (hc_q == '0) begin
         x_d = '0;
      end else if (req_q && (x_q != XLast)) begin
         x_d = x_q + 1'b1;
      end

      y_d = act_line ? YW'(vc_q - VaBeg) : y_q;

      visible_d     = in_win;
      line_start_d  = (hc_q == '0);
      frame_start_d = (hc_q == '0) && (vc_q == '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hc_q          <= '0;
         vc_q          <= '0;
         div_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         sync_q        <= 1'b1;
         visible_q     <= 1'b0;
         req_q         <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         field_out_q   <= 1'b0;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         div_q         <= div_d;
         x_q           <= x_d;
         y_q           <= y_d;
         sync_q        <= sync_d;
         visible_q     <= visible_d;
         req_q         <= req_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         field_out_q   <= field_q;
      end
   end

   assign vid.sync        = sync_q;
   assign vid.visible     = visible_q;
   assign vid.x           = x_q;
   assign vid.y           = y_q;
   assign vid.req         = req_q;
   assign vid.line_start  = line_start_q;
   assign vid.frame_start = frame_start_q;
   assign vid.field       = field_out_q;
   // data/valid arrive on the clock that visible_q marks, so the gate is applied directly.
   assign vid.pixel       = visible_q & vid.data & vid.valid;

endmodule
